// File: rtl/red_iter_if.sv
// Operand/result handshake bundle for the lane-reduction unit.
// slave = the reduction unit, master = the issuing stage / consumer.
interface red_iter_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              sign_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] Sum;

    modport master (
        output in_valid, A, B, sign_mode, out_ready,
        input  in_ready, out_valid, Sum
    );

    modport slave (
        input  in_valid, A, B, sign_mode, out_ready,
        output in_ready, out_valid, Sum
    );
endinterface

// File: rtl/red_iter_unit.sv
// Multi-cycle lane reduction: sums all LANE_W-bit lanes of A and B, LPC lane
// pairs per beat, signed or unsigned, with valid/ready on both sides.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | in_ready high, waiting for operands
// ACCUM | summing LPC lane pairs per cycle into acc
// DONE  | out_valid high, Sum held until out_ready
module red_iter_unit #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4,
    parameter int LPC    = 1
) (
    input  logic      clk,
    input  logic      rst,
    red_iter_if.slave bus
);
    localparam int LANES  = DATA_W / LANE_W;
    localparam int ITER   = LANES / LPC;
    localparam int ACC_W  = LANE_W + $clog2(2 * LANES) + 1;
    localparam int IDX_W  = $clog2(LANES + 1);
    localparam int BEAT_W = LPC * LANE_W;

    generate
        if (DATA_W % LANE_W != 0) begin : g_bad_lane_w
            $error("red_iter_unit: DATA_W must be a multiple of LANE_W");
        end
        if (LANES % LPC != 0) begin : g_bad_lpc
            $error("red_iter_unit: LANES must be a multiple of LPC");
        end
        if (ACC_W > DATA_W) begin : g_bad_acc_w
            $error("red_iter_unit: accumulator wider than DATA_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              sign_q;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  beat_sum;
    logic [ACC_W-1:0]  acc_sum;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] sum_q;
    logic              last_beat;

    function automatic logic [ACC_W-1:0] ext_lane(input logic [LANE_W-1:0] lane,
                                                  input logic sgn);
        return sgn ? ACC_W'($signed(lane)) : ACC_W'(lane);
    endfunction

    // Operand registers shift down each beat, so the current lanes are always the low ones.
    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < LPC; l++) begin
            beat_sum = beat_sum + ext_lane(a_q[l*LANE_W +: LANE_W], sign_q)
                                + ext_lane(b_q[l*LANE_W +: LANE_W], sign_q);
        end
        acc_sum = acc + beat_sum;
    end

    assign last_beat = (idx + IDX_W'(LPC)) == IDX_W'(LANES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = ACCUM;
            end
            ACCUM: begin
                if (last_beat) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sign_q <= 1'b0;
            acc    <= '0;
            idx    <= '0;
            sum_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        sign_q <= bus.sign_mode;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc_sum;
                    idx <= idx + IDX_W'(LPC);
                    a_q <= a_q >> BEAT_W;
                    b_q <= b_q >> BEAT_W;
                    if (last_beat) begin
                        sum_q <= sign_q ? DATA_W'($signed(acc_sum)) : DATA_W'(acc_sum);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Sum = sum_q;

endmodule

// File: tb/tb_red_iter_unit.sv
// Directed bench for red_iter_unit: LPC=1, 2 and 4 instances, reference-model
// scoreboard, latency/backpressure/reset-abort checks.
module tb_red_iter_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  drv_valid = '0;
    logic [15:0] drv_a = '0;
    logic [15:0] drv_b = '0;
    logic        drv_sign = 1'b0;
    logic        drv_ordy = 1'b0;
    int          sel = 0;
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q[$];

    logic        o_iready;
    logic        o_ovalid;
    logic [15:0] o_sum;

    always #5 clk = ~clk;

    red_iter_if #(.DATA_W(16)) bus1 ();
    red_iter_if #(.DATA_W(16)) bus2 ();
    red_iter_if #(.DATA_W(16)) bus4 ();

    assign bus1.in_valid = drv_valid[0];
    assign bus2.in_valid = drv_valid[1];
    assign bus4.in_valid = drv_valid[2];
    assign bus1.A = drv_a;  assign bus2.A = drv_a;  assign bus4.A = drv_a;
    assign bus1.B = drv_b;  assign bus2.B = drv_b;  assign bus4.B = drv_b;
    assign bus1.sign_mode = drv_sign;
    assign bus2.sign_mode = drv_sign;
    assign bus4.sign_mode = drv_sign;
    assign bus1.out_ready = drv_ordy;
    assign bus2.out_ready = drv_ordy;
    assign bus4.out_ready = drv_ordy;

    red_iter_unit #(.DATA_W(16), .LANE_W(4), .LPC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    red_iter_unit #(.DATA_W(16), .LANE_W(4), .LPC(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    red_iter_unit #(.DATA_W(16), .LANE_W(4), .LPC(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always_comb begin
        o_iready = bus1.in_ready;
        o_ovalid = bus1.out_valid;
        o_sum    = bus1.Sum;
        case (sel)
            1: begin o_iready = bus2.in_ready; o_ovalid = bus2.out_valid; o_sum = bus2.Sum; end
            2: begin o_iready = bus4.in_ready; o_ovalid = bus4.out_valid; o_sum = bus4.Sum; end
            default: ;
        endcase
    end

    function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic sgn);
        int s = 0;
        logic [3:0] la, lb;
        for (int i = 0; i < 4; i++) begin
            la = a[i*4 +: 4];
            lb = b[i*4 +: 4];
            if (sgn) s += int'($signed(la)) + int'($signed(lb));
            else     s += int'(la) + int'(lb);
        end
        return 16'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation on instance s: accept, latency, hold under backpressure, drain.
    task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                          input logic sgn, input int hold, input string tag);
        int cyc;
        logic [15:0] e;
        sel = s;
        cyc = 0;
        #1;
        while (!o_iready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk({tag, "_ready_wait"}, 32'(cyc < 20), 32'd1);
        drv_a = a; drv_b = b; drv_sign = sgn;
        drv_valid[s] = 1'b1;
        exp_q.push_back(ref_sum(a, b, sgn));
        @(posedge clk); #1;
        drv_valid = '0;
        drv_a = ~a; drv_b = ~b; drv_sign = ~sgn;
        chk({tag, "_busy"}, 32'(o_iready), 32'd0);
        cyc = 0;
        while (!o_ovalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk({tag, "_latency"}, 32'(cyc), 32'(4 >> s));
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            e = 'x;
        end else begin
            e = exp_q.pop_front();
        end
        chk({tag, "_sum"}, 32'(o_sum), 32'(e));
        for (int h = 0; h < hold; h++) begin
            drv_valid[s] = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(o_ovalid), 32'd1);
            chk({tag, "_hold_sum"}, 32'(o_sum), 32'(e));
            chk({tag, "_hold_iready"}, 32'(o_iready), 32'd0);
        end
        drv_valid = '0;
        drv_ordy = 1'b1;
        @(posedge clk); #1;
        drv_ordy = 1'b0;
        chk({tag, "_drain_valid"}, 32'(o_ovalid), 32'd0);
        chk({tag, "_drain_iready"}, 32'(o_iready), 32'd1);
    endtask

    initial begin
        int seen;
        logic [15:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_iready", 32'(bus1.in_ready), 32'd1);
        chk("rst_ovalid", 32'(bus1.out_valid), 32'd0);
        chk("rst_sum", 32'(bus1.Sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);

        run_op(0, 16'h1234, 16'h5678, 1'b0, 0, "t2_unsigned");
        run_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 0, "t3_signed_ff");
        run_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 0, "t3_unsigned_ff");
        run_op(0, 16'h8888, 16'h8888, 1'b1, 5, "t4_backpressure");

        // Abort an op with reset during the second ACCUM beat.
        sel = 0;
        #1;
        drv_a = 16'h7777; drv_b = 16'h7777; drv_sign = 1'b0;
        drv_valid[0] = 1'b1;
        @(posedge clk); #1;
        drv_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_iready", 32'(o_iready), 32'd1);
        chk("t5_rst_ovalid", 32'(o_ovalid), 32'd0);
        chk("t5_rst_sum", 32'(o_sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (o_ovalid) seen++;
        end
        chk("t5_no_output", 32'(seen), 32'd0);
        run_op(0, 16'h0001, 16'h0000, 1'b0, 0, "t5_after");

        run_op(2, 16'h1234, 16'h5678, 1'b0, 0, "t6_lpc4");
        run_op(1, 16'h1234, 16'h5678, 1'b0, 0, "t6_lpc2");
        run_op(1, 16'h8888, 16'h8888, 1'b1, 2, "t6_lpc2_signed");

        for (int k = 0; k < 6; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(k % 3, ra, rb, 1'($urandom_range(0, 1)), k % 2, "rand");
        end

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
